// File: rtl/beat_controller.sv
// beat_controller: hardwired micro-operation controller for the model computer.
//
// Decodes the 8-beat one-hot timing ring and the registered instruction byte into
// per-beat control strobes (fetch at T0..T2, opcode-dependent execute at T3..T5).
//
// Ports:
//   clk        system clock, rising edge
//   CLEAR      asynchronous active-high reset
//   T[7:0]     one-hot beat ring, T[0] is beat 0
//   ir_in      instruction byte from the memory bus, captured at the end of T1
//   ctrl       control strobes: 0 PC_OUT, 1 MAR_IN, 2 MEM_RD, 3 IR_IN, 4 PC_INC,
//              5 IR_OUT, 6 ACC_IN, 7 B_IN, 8 ALU_OUT, 9 ALU_SUB, 10 ACC_OUT,
//              11 MEM_WR, 12 PC_IN, 13 OUT_IN
//   opcode     IR[7:4], registered
//   addr_out   IR[3:0], registered operand address
//   halted     high while halted
//   sync_err   high while in the ring-error state (sticky until CLEAR)
//   instr_cnt  retired-instruction count, wraps
//
// Build option BEAT_ONEHOT_CHECK_EN: when defined, the expected beat is tracked and
// any ring other than the expected one-hot value traps into the error state. When
// undefined, beats are decoded straight from the T bits and sync_err is tied low.

module beat_controller #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  HLT_OPC = 4'hF
) (
  input  logic             clk,
  input  logic             CLEAR,
  input  logic [7:0]       T,
  input  logic [7:0]       ir_in,
  output logic [13:0]      ctrl,
  output logic [3:0]       opcode,
  output logic [3:0]       addr_out,
  output logic             halted,
  output logic             sync_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned PcOut  = 0;
  localparam int unsigned MarIn  = 1;
  localparam int unsigned MemRd  = 2;
  localparam int unsigned IrIn   = 3;
  localparam int unsigned PcInc  = 4;
  localparam int unsigned IrOut  = 5;
  localparam int unsigned AccIn  = 6;
  localparam int unsigned BIn    = 7;
  localparam int unsigned AluOut = 8;
  localparam int unsigned AluSub = 9;
  localparam int unsigned AccOut = 10;
  localparam int unsigned MemWr  = 11;
  localparam int unsigned PcIn   = 12;
  localparam int unsigned OutIn  = 13;

  localparam logic [CNT_W-1:0] CntOne = 1;

`ifdef BEAT_ONEHOT_CHECK_EN
  typedef enum logic [1:0] {StIdle, StRun, StHalt, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;
`endif

  state_e           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wake;
  logic [7:0]       beat;
  logic [7:0]       beat_live;

`ifdef BEAT_ONEHOT_CHECK_EN
  logic [2:0] bidx_q, bidx_d;
  logic       beat_ok;

  assign beat_ok = (T == (8'h01 << bidx_q));
  assign wake    = (T == 8'h01);
  assign beat    = (state_q == StRun && beat_ok) ? (8'h01 << bidx_q) : 8'h00;
`else
  assign wake = T[0];
  assign beat = (state_q == StRun) ? T : 8'h00;
`endif

  // The beats that follow the waking T0 belong to no instruction: nothing was
  // fetched, so only T0 may fire until the first real fetch has begun.
  assign beat_live = beat & {{7{primed_q}}, 1'b1};

  always_comb begin
    ctrl = '0;
    if (beat_live[0]) begin
      ctrl[PcOut] = 1'b1;
      ctrl[MarIn] = 1'b1;
    end
    if (beat_live[1]) begin
      ctrl[MemRd] = 1'b1;
      ctrl[IrIn]  = 1'b1;
    end
    if (beat_live[2]) ctrl[PcInc] = 1'b1;
    if (opcode != HLT_OPC) begin
      unique case (opcode)
        4'h1: begin
          if (beat_live[3]) begin ctrl[IrOut] = 1'b1; ctrl[MarIn] = 1'b1; end
          if (beat_live[4]) begin ctrl[MemRd] = 1'b1; ctrl[AccIn] = 1'b1; end
        end
        4'h2, 4'h3: begin
          if (beat_live[3]) begin ctrl[IrOut] = 1'b1; ctrl[MarIn] = 1'b1; end
          if (beat_live[4]) begin ctrl[MemRd] = 1'b1; ctrl[BIn] = 1'b1; end
          if (beat_live[5]) begin
            ctrl[AluOut] = 1'b1;
            ctrl[AccIn]  = 1'b1;
            ctrl[AluSub] = (opcode == 4'h3);
          end
        end
        4'h4: begin
          if (beat_live[3]) begin ctrl[IrOut] = 1'b1; ctrl[MarIn] = 1'b1; end
          if (beat_live[4]) begin ctrl[AccOut] = 1'b1; ctrl[MemWr] = 1'b1; end
        end
        4'h5: if (beat_live[3]) begin ctrl[IrOut] = 1'b1; ctrl[PcIn] = 1'b1; end
        4'h6: if (beat_live[3]) begin ctrl[AccOut] = 1'b1; ctrl[OutIn] = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    primed_d = primed_q;
    cnt_d    = cnt_q;
`ifdef BEAT_ONEHOT_CHECK_EN
    bidx_d   = bidx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (wake) state_d = StRun;
`ifdef BEAT_ONEHOT_CHECK_EN
        bidx_d = wake ? 3'd1 : 3'd0;
`endif
      end
      StRun: begin
`ifdef BEAT_ONEHOT_CHECK_EN
        bidx_d = bidx_q + 3'd1;
        if (!beat_ok) state_d = StErr;
`endif
        if (beat_live[0]) primed_d = 1'b1;
        if (beat_live[1]) ir_d = ir_in;
        if (beat_live[3] && opcode == HLT_OPC) begin
          state_d = StHalt;
        end else if (beat_live[7]) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge CLEAR) begin
    if (CLEAR) begin
      state_q  <= StIdle;
      ir_q     <= 8'h00;
      primed_q <= 1'b0;
      cnt_q    <= '0;
`ifdef BEAT_ONEHOT_CHECK_EN
      bidx_q   <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
`ifdef BEAT_ONEHOT_CHECK_EN
      bidx_q   <= bidx_d;
`endif
    end
  end

  assign opcode    = ir_q[7:4];
  assign addr_out  = ir_q[3:0];
  assign halted    = (state_q == StHalt);
  assign instr_cnt = cnt_q;
`ifdef BEAT_ONEHOT_CHECK_EN
  assign sync_err  = (state_q == StErr);
`else
  assign sync_err  = 1'b0;
`endif

endmodule

// File: tb/tb_beat_controller.sv
// Self-checking bench for beat_controller (instantiated with CNT_W=4 so the
// counter wrap is reachable in a few hundred cycles).

module tb_beat_controller;

  logic       clk;
  logic       CLEAR;
  logic [7:0] T;
  logic [7:0] ir_in;
  logic [13:0] ctrl;
  logic [3:0] opcode;
  logic [3:0] addr_out;
  logic       halted;
  logic       sync_err;
  logic [3:0] instr_cnt;

  beat_controller #(
    .CNT_W  (4),
    .HLT_OPC(4'hF)
  ) dut (
    .clk      (clk),
    .CLEAR    (CLEAR),
    .T        (T),
    .ir_in    (ir_in),
    .ctrl     (ctrl),
    .opcode   (opcode),
    .addr_out (addr_out),
    .halted   (halted),
    .sync_err (sync_err),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [13:0] beats_t [8];
  typedef struct packed {
    logic [7:0]  t;
    logic [7:0]  ir;
    logic [13:0] c;
  } vec_t;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [13:0] exp_q [$];

  beats_t e_nop, e_lda, e_add, e_sub, e_sta, e_jmp, e_out, e_hlt;
  vec_t   tbl [16];

  function automatic logic [7:0] ring(input int k);
    logic [7:0] one;
    one = 8'h01;
    return one << k;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one beat just after a rising edge, check ctrl mid-cycle, end at edge+1.
  task automatic cyc(input string nm, input logic [7:0] t, input logic [7:0] ir,
                     input logic [13:0] ec);
    logic [13:0] e;
    T     = t;
    ir_in = ir;
    exp_q.push_back(ec);
    #2;
    e = exp_q.pop_front();
    chk(nm, {18'h0, ctrl}, {18'h0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [7:0] ir, input beats_t e);
    for (int k = 0; k < 8; k++) cyc(nm, ring(k), (k == 1) ? ir : 8'hFF, e[k]);
  endtask

  task automatic do_reset();
    CLEAR = 1'b1;
    T     = 8'h00;
    ir_in = 8'h00;
    #1;
    chk("rst_ctrl", {18'h0, ctrl}, 32'h0);
    chk("rst_cnt", {28'h0, instr_cnt}, 32'h0);
    chk("rst_flags", {30'h0, halted, sync_err}, 32'h0);
    @(posedge clk);
    #1;
    CLEAR = 1'b0;
  endtask

  // Reset, wake on T0, then the unfetched warm-up beats T1..T7.
  task automatic start();
    do_reset();
    cyc("wake", 8'h01, 8'hFF, 14'h0);
    for (int k = 1; k < 8; k++) cyc("warmup", ring(k), 8'hFF, 14'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    CLEAR = 1'b1;
    T     = 8'h00;
    ir_in = 8'h00;

    e_nop = '{14'h003, 14'h00C, 14'h010, 14'h000, 14'h000, 14'h000, 14'h000, 14'h000};
    e_lda = '{14'h003, 14'h00C, 14'h010, 14'h022, 14'h044, 14'h000, 14'h000, 14'h000};
    e_add = '{14'h003, 14'h00C, 14'h010, 14'h022, 14'h084, 14'h140, 14'h000, 14'h000};
    e_sub = '{14'h003, 14'h00C, 14'h010, 14'h022, 14'h084, 14'h340, 14'h000, 14'h000};
    e_sta = '{14'h003, 14'h00C, 14'h010, 14'h022, 14'hC00, 14'h000, 14'h000, 14'h000};
    e_jmp = '{14'h003, 14'h00C, 14'h010, 14'h1020, 14'h000, 14'h000, 14'h000, 14'h000};
    e_out = '{14'h003, 14'h00C, 14'h010, 14'h2400, 14'h000, 14'h000, 14'h000, 14'h000};
    e_hlt = '{14'h003, 14'h00C, 14'h010, 14'h000, 14'h000, 14'h000, 14'h000, 14'h000};

    // Wake, warm-up, then one ADD 0xA.
    tbl[0] = {8'h01, 8'hFF, 14'h0};
    for (int k = 1; k < 8; k++) tbl[k] = {ring(k), 8'hFF, 14'h0};
    for (int k = 0; k < 8; k++) tbl[8 + k] = {ring(k), (k == 1) ? 8'h2A : 8'hFF, e_add[k]};

    // Table-driven fetch + ADD.
    do_reset();
    chk("rst_opcode", {24'h0, opcode, addr_out}, 32'h0);
    for (int i = 0; i < 16; i++) cyc("add_tbl", tbl[i].t, tbl[i].ir, tbl[i].c);
    chk("add_addr", {28'h0, addr_out}, 32'hA);
    chk("add_opcode", {28'h0, opcode}, 32'h2);
    chk("add_cnt", {28'h0, instr_cnt}, 32'h1);

    // Program LDA 3, SUB 4, STA 5, OUT.
    start();
    run_instr("lda", 8'h13, e_lda);
    chk("lda_addr", {28'h0, addr_out}, 32'h3);
    run_instr("sub", 8'h34, e_sub);
    run_instr("sta", 8'h45, e_sta);
    chk("sta_addr", {28'h0, addr_out}, 32'h5);
    run_instr("out", 8'h60, e_out);
    chk("prog_cnt", {28'h0, instr_cnt}, 32'h4);
    chk("prog_opcode", {28'h0, opcode}, 32'h6);

    // HLT: halts on the T3 edge, nothing afterwards, not retired.
    start();
    for (int k = 0; k < 3; k++) cyc("hlt_fetch", ring(k), (k == 1) ? 8'hF0 : 8'hFF, e_hlt[k]);
    chk("hlt_pre", {31'h0, halted}, 32'h0);
    cyc("hlt_t3", ring(3), 8'hFF, 14'h0);
    chk("hlt_t3edge", {31'h0, halted}, 32'h1);
    for (int k = 4; k < 16; k++) cyc("hlt_idle", ring(k % 8), 8'h00, 14'h0);
    chk("hlt_stay", {31'h0, halted}, 32'h1);
    chk("hlt_cnt", {28'h0, instr_cnt}, 32'h0);
    do_reset();
    cyc("hlt_rewake", 8'h01, 8'hFF, 14'h0);
    chk("hlt_cleared", {31'h0, halted}, 32'h0);

    // Illegal ring 8'h05 at beat 2 of a NOP.
    start();
    cyc("err_t0", ring(0), 8'hFF, 14'h003);
    cyc("err_t1", ring(1), 8'h00, 14'h00C);
`ifdef BEAT_ONEHOT_CHECK_EN
    cyc("err_bad", 8'h05, 8'hFF, 14'h000);
    chk("err_sync", {31'h0, sync_err}, 32'h1);
    for (int k = 3; k < 16; k++) cyc("err_dead", ring(k % 8), 8'h00, 14'h0);
    chk("err_sticky", {31'h0, sync_err}, 32'h1);
    chk("err_cnt", {28'h0, instr_cnt}, 32'h0);
`else
    // T0 and T2 strobes both fire on the multi-hot ring.
    cyc("err_bad", 8'h05, 8'hFF, 14'h013);
    chk("err_sync", {31'h0, sync_err}, 32'h0);
    for (int k = 3; k < 8; k++) cyc("err_rest", ring(k), 8'hFF, 14'h0);
    run_instr("err_next", 8'h00, e_nop);
    chk("err_sticky", {31'h0, sync_err}, 32'h0);
    chk("err_cnt", {28'h0, instr_cnt}, 32'h2);
`endif

    // CLEAR during T4 of an LDA.
    start();
    run_instr("clr_nop", 8'h00, e_nop);
    for (int k = 0; k < 4; k++) cyc("clr_lda", ring(k), (k == 1) ? 8'h17 : 8'hFF, e_lda[k]);
    T = ring(4);
    #2;
    chk("clr_t4", {18'h0, ctrl}, 32'h044);
    CLEAR = 1'b1;
    #1;
    chk("clr_ctrl", {18'h0, ctrl}, 32'h0);
    chk("clr_ir", {24'h0, opcode, addr_out}, 32'h0);
    chk("clr_cnt", {28'h0, instr_cnt}, 32'h0);
    @(posedge clk);
    #1;
    CLEAR = 1'b0;
    for (int k = 5; k < 8; k++) cyc("clr_idle", ring(k), 8'hFF, 14'h0);
    cyc("clr_wake", 8'h01, 8'hFF, 14'h0);
    for (int k = 1; k < 8; k++) cyc("clr_warm", ring(k), 8'hFF, 14'h0);
    run_instr("clr_first", 8'h00, e_nop);
    chk("clr_retire", {28'h0, instr_cnt}, 32'h1);

    // Counter wrap with CNT_W=4.
    start();
    run_instr("jmp", 8'h57, e_jmp);
    chk("jmp_addr", {28'h0, addr_out}, 32'h7);
    for (int i = 0; i < 14; i++) run_instr("wrap_nop", 8'h00, e_nop);
    chk("wrap_full", {28'h0, instr_cnt}, 32'hF);
    run_instr("wrap_nop", 8'h00, e_nop);
    chk("wrap_zero", {28'h0, instr_cnt}, 32'h0);
    run_instr("wrap_nop", 8'h00, e_nop);
    chk("wrap_one", {28'h0, instr_cnt}, 32'h1);

    chk("sb_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_controller.md
Name: beat_controller

Overview:
- Hardwired micro-operation controller for the model computer.
- Consumes the 8-beat one-hot timing ring T[7:0] from the beat generator and the instruction word from the memory bus.
- Emits per-beat control strobes to the PC, MAR, memory, IR, ACC, B register, ALU and output port.
- Tracks the expected beat and traps on any ring that is not the expected one-hot value.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- HLT_OPC, 4'hF: opcode that halts the machine.

Ports:
- clk  in  1  system clock, rising edge.
- CLEAR  in  1  reset, asynchronous, active-high.
- T  in  8  one-hot beat ring; T[0] is beat 0.
- ir_in  in  8  instruction byte on the memory bus, sampled at the end of beat 1.
- ctrl  out  14  control strobes:
  - bit 0 PC_OUT, 1 MAR_IN, 2 MEM_RD, 3 IR_IN, 4 PC_INC
  - bit 5 IR_OUT, 6 ACC_IN, 7 B_IN, 8 ALU_OUT, 9 ALU_SUB
  - bit 10 ACC_OUT, 11 MEM_WR, 12 PC_IN, 13 OUT_IN
- opcode  out  4  IR[7:4], registered.
- addr_out  out  4  IR[3:0], registered; the operand address.
- halted  out  1  high while in HALT.
- sync_err  out  1  sticky; high while in ERR.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (CLEAR=1) forces: state IDLE, beat index bidx=0, IR=8'h00, instr_cnt=0, halted=0, sync_err=0, ctrl=0.
- The state machine has four states: IDLE, RUN, HALT, ERR.
- IDLE:
  - ctrl=0.
  - On a clk edge with T==8'h01, go to RUN with bidx=1.
  - The first instruction therefore begins at the next T0, 8 cycles later.
- RUN:
  - Each cycle, beat_ok = (T == 1<<bidx).
  - bidx increments mod 8 on every edge.
  - If beat_ok=0 (all-zero, multi-hot or wrong beat): ctrl=0 in that cycle, and go to ERR on the next edge.
- ctrl is a combinational function of T, the state and the registered IR. It is nonzero only in RUN with beat_ok=1.
- Fetch, all opcodes:
  - T0: PC_OUT, MAR_IN.
  - T1: MEM_RD, IR_IN. IR <= ir_in on this edge.
  - T2: PC_INC.
- Execute, selected by opcode (IR[7:4]):
  - 1 LDA: T3 IR_OUT+MAR_IN; T4 MEM_RD+ACC_IN.
  - 2 ADD: T3 IR_OUT+MAR_IN; T4 MEM_RD+B_IN; T5 ALU_OUT+ACC_IN.
  - 3 SUB: as ADD, plus ALU_SUB at T5.
  - 4 STA: T3 IR_OUT+MAR_IN; T4 ACC_OUT+MEM_WR.
  - 5 JMP: T3 IR_OUT+PC_IN.
  - 6 OUT: T3 ACC_OUT+OUT_IN.
  - HLT_OPC: no strobes; go to HALT on the T3 edge; not counted as retired.
  - 0 and all other undefined opcodes: NOP, no execute strobes.
- T6 and T7 carry no strobes for any opcode.
- Retire: on the T7 edge in RUN with beat_ok=1, instr_cnt += 1, wrapping to 0 after all-ones.
- HALT: ctrl=0, halted=1, T ignored. Left only via CLEAR.
- ERR: ctrl=0, sync_err=1, T ignored. Left only via CLEAR.
- CLEAR asserted mid-instruction: immediate return to the reset values with no completing strobes, and the instruction is not retired.
- opcode and addr_out update on the T1 edge and hold until the next fetch.

Optional Feature:
- Macro: BEAT_ONEHOT_CHECK_EN.
- Defined: behaviour exactly as above, including the bidx tracker, the beat_ok gating and the ERR state.
- Undefined:
  - No bidx tracker and no ERR state; sync_err is tied to 0.
  - Beats are decoded directly from the individual T bits.
  - IDLE goes to RUN on the first T[0]=1.
  - An illegal ring can assert the strobes of several beats at once; this is accepted behaviour.

Test Plan:
- Fetch and ADD: reset, free-running ring, ir_in=8'h2A at T1 -> the following all match:
  - ctrl=0x003 at T0, 0x00C at T1, 0x010 at T2, 0x022 at T3, 0x084 at T4, 0x140 at T5;
  - addr_out=4'hA; instr_cnt=1 after T7.
- Program LDA 3, SUB 4, STA 5, OUT -> ALU_SUB is high only in SUB's T5; MEM_WR only in STA's T4; instr_cnt=4.
- HLT (ir_in=8'hF0) -> ctrl=0 from T3 onward, halted=1 on the T3 edge, instr_cnt unchanged; a CLEAR pulse returns to IDLE.
- Inject T=8'h05 at beat 2 (define on) -> ctrl=0 that cycle, sync_err=1 next edge and stays set; with the macro undefined, sync_err stays 0.
- Assert CLEAR during T4 of an LDA -> all outputs return to reset values immediately; the next instruction starts at the first T0 following T==8'h01.
- Force instr_cnt to all-ones with CNT_W=4, execute 2 NOPs -> the count wraps to 0, then reads 1.
